// File: rtl/fetch_unit.sv
// Fetch stage: generates fetch PCs, keeps one I-cache request in flight and
// pushes predicted instruction entries into the fetch-to-decode buffer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          GHR_BITS = 8,
   parameter int          GH       = GHR_BITS
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          redirect_valid_i,
   input  logic [31:0]   redirect_pc_i,
   output logic          icache_req_valid_o,
   output logic [31:0]   icache_req_addr_o,
   input  logic          icache_req_ready_i,
   input  logic          icache_rsp_valid_i,
   input  logic [31:0]   icache_rsp_inst_i,
   output logic [31:0]   bp_pc_o,
   input  logic          bp_pred_taken_i,
   input  logic [31:0]   bp_pred_target_i,
   input  logic [GH-1:0] bp_ghr_i,
   input  logic          ibuf_full_i,
   output logic          ibuf_flush_o,
   output logic          ibuf_push_o,
   output logic [31:0]   ibuf_pc_o,
   output logic [31:0]   ibuf_inst_o,
   output logic          ibuf_pred_taken_o,
   output logic [31:0]   ibuf_pred_target_o,
   output logic [GH-1:0] ibuf_ghr_snapshot_o
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [31:0]     r_pc;
   logic [31:0]     r_req_pc;
   logic            r_pred_taken;
   logic [31:0]     r_pred_target;
   logic [GH-1:0]   r_pred_ghr;
   logic [31:0]     r_hold_inst;
   logic            w_accept;
   logic            w_hold_capture;

   // The request is always valid in REQ, so acceptance only needs ready.
   assign w_accept       = (r_state == S_REQ) && icache_req_ready_i;
   assign w_hold_capture = (r_state == S_WAIT) && icache_rsp_valid_i &&
                           ibuf_full_i && !redirect_valid_i;

   always_ff @(posedge clock) begin
      if (!reset_n) r_state <= S_REQ;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_REQ: begin
            if (w_accept) w_next_state = redirect_valid_i ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            if (redirect_valid_i)
               w_next_state = icache_rsp_valid_i ? S_REQ : S_DRAIN;
            else if (icache_rsp_valid_i)
               w_next_state = ibuf_full_i ? S_HOLD : S_REQ;
         end
         S_HOLD: begin
            if (redirect_valid_i || !ibuf_full_i) w_next_state = S_REQ;
         end
         S_DRAIN: begin
            if (icache_rsp_valid_i) w_next_state = S_REQ;
         end
         default: w_next_state = S_REQ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_pc          <= RESET_PC;
         r_req_pc      <= '0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= '0;
         r_pred_ghr    <= '0;
         r_hold_inst   <= '0;
      end else begin
         if (redirect_valid_i)
            r_pc <= {redirect_pc_i[31:2], 2'b00};
         else if (w_accept)
            r_pc <= bp_pred_taken_i ? {bp_pred_target_i[31:2], 2'b00} : r_pc + 32'd4;
         // Latching on a redirected accept is harmless: DRAIN discards that response.
         if (w_accept) begin
            r_req_pc      <= r_pc;
            r_pred_taken  <= bp_pred_taken_i;
            r_pred_target <= bp_pred_target_i;
            r_pred_ghr    <= bp_ghr_i;
         end
         if (w_hold_capture) r_hold_inst <= icache_rsp_inst_i;
      end
   end

   always_comb begin
      icache_req_valid_o  = 1'b0;
      icache_req_addr_o   = '0;
      bp_pc_o             = '0;
      ibuf_flush_o        = 1'b0;
      ibuf_push_o         = 1'b0;
      ibuf_pc_o           = '0;
      ibuf_inst_o         = '0;
      ibuf_pred_taken_o   = 1'b0;
      ibuf_pred_target_o  = '0;
      ibuf_ghr_snapshot_o = '0;
      if (reset_n) begin
         icache_req_addr_o   = r_pc;
         bp_pc_o             = r_pc;
         ibuf_flush_o        = redirect_valid_i;
         ibuf_pc_o           = r_req_pc;
         ibuf_inst_o         = (r_state == S_HOLD) ? r_hold_inst : icache_rsp_inst_i;
         ibuf_pred_taken_o   = r_pred_taken;
         ibuf_pred_target_o  = r_pred_target;
         ibuf_ghr_snapshot_o = r_pred_ghr;
         case (r_state)
            S_REQ:   icache_req_valid_o = 1'b1;
            S_WAIT:  ibuf_push_o = icache_rsp_valid_i && !ibuf_full_i && !redirect_valid_i;
            S_HOLD:  ibuf_push_o = !ibuf_full_i && !redirect_valid_i;
            default: ibuf_push_o = 1'b0;
         endcase
      end
   end

   // Only one request can be outstanding, so a response in REQ/HOLD is a cache bug.
   always_ff @(posedge clock) begin
      if (reset_n)
         assert (!(icache_rsp_valid_i && (r_state == S_REQ || r_state == S_HOLD)));
   end

endmodule
